// File: rtl/mem_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_arbiter_pkg
// Description : Shared types for the two-port memory access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_arbiter_pkg;

    localparam int unsigned C_ADDR_W = 32;
    localparam int unsigned C_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_RDATA = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic                write;
        logic [C_ADDR_W-1:0] addr;
        logic [C_DATA_W-1:0] wdata;
        logic [C_DATA_W-1:0] wmask;
    } req_slot_t;

    // Round-robin only matters under contention; otherwise the pending port wins.
    function automatic owner_t pick_winner(input logic rr, input logic pend_i,
                                           input logic pend_d, input owner_t last);
        owner_t w;
        if (rr && pend_i && pend_d)
            w = (last == OWNER_D) ? OWNER_I : OWNER_D;
        else if (pend_d)
            w = OWNER_D;
        else
            w = OWNER_I;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_arbiter_if
// Description : Fetch, data and controller buses of the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_arbiter_if;
    import mem_access_arbiter_pkg::*;

    logic                i_cmd_start;
    logic                i_cmd_ready;
    logic [C_ADDR_W-1:0] i_addr;
    logic [C_DATA_W-1:0] i_rdata;
    logic                i_rdata_valid;

    logic                d_cmd_start;
    logic                d_cmd_write;
    logic                d_cmd_ready;
    logic [C_ADDR_W-1:0] d_addr;
    logic [C_DATA_W-1:0] d_wdata;
    logic [C_DATA_W-1:0] d_wmask;
    logic [C_DATA_W-1:0] d_rdata;
    logic                d_rdata_valid;

    logic                m_cmd_start;
    logic                m_cmd_write;
    logic                m_cmd_ready;
    logic [C_ADDR_W-1:0] m_addr;
    logic [C_DATA_W-1:0] m_wdata;
    logic [C_DATA_W-1:0] m_wmask;
    logic [C_DATA_W-1:0] m_rdata;
    logic                m_rdata_valid;

    // Arbiter side
    modport slave (
        input  i_cmd_start, i_addr,
        output i_cmd_ready, i_rdata, i_rdata_valid,
        input  d_cmd_start, d_cmd_write, d_addr, d_wdata, d_wmask,
        output d_cmd_ready, d_rdata, d_rdata_valid,
        output m_cmd_start, m_cmd_write, m_addr, m_wdata, m_wmask,
        input  m_cmd_ready, m_rdata, m_rdata_valid
    );

    // Requester / controller side
    modport master (
        output i_cmd_start, i_addr,
        input  i_cmd_ready, i_rdata, i_rdata_valid,
        output d_cmd_start, d_cmd_write, d_addr, d_wdata, d_wmask,
        input  d_cmd_ready, d_rdata, d_rdata_valid,
        input  m_cmd_start, m_cmd_write, m_addr, m_wdata, m_wmask,
        output m_cmd_ready, m_rdata, m_rdata_valid
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_arbiter_slot.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_slot
// Description : One-entry request holding register with ready/pend logic.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_slot
    import mem_access_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_start,
    input  logic      i_busy,
    input  logic      i_clear,
    input  req_slot_t i_req,
    output logic      o_ready,
    output logic      o_pend,
    output req_slot_t o_req
);

    logic      r_pend;
    req_slot_t r_req;
    logic      w_ready;

    // A port whose own transaction is in flight cannot refill until it completes.
    assign w_ready = !r_pend && !i_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_req  <= '0;
        end else if (i_clear) begin
            r_pend <= 1'b0;
        end else if (i_start && w_ready) begin
            r_pend <= 1'b1;
            r_req  <= i_req;
        end
    end

    assign o_ready = w_ready;
    assign o_pend  = r_pend;
    assign o_req   = r_req;

endmodule
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_arbiter
// Description : Shares one memory controller between fetch (I) and data (D).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_access_arbiter_if.slave  bus,
    output logic                 err_spurious
);

    state_t    r_state;
    state_t    w_state_nxt;
    owner_t    r_owner;
    owner_t    r_last_grant;
    owner_t    w_winner;
    req_slot_t r_payload;
    logic      r_err;

    logic      w_grant;
    logic      w_issue;
    logic      w_clear_i, w_clear_d;
    logic      w_rvalid_i, w_rvalid_d;
    logic      w_busy_i, w_busy_d;
    logic      w_ready_i, w_ready_d;
    logic      w_pend_i, w_pend_d;
    req_slot_t w_req_i, w_req_d;
    req_slot_t w_slot_i, w_slot_d;

    assign w_busy_i = (r_state != ST_IDLE) && (r_owner == OWNER_I);
    assign w_busy_d = (r_state != ST_IDLE) && (r_owner == OWNER_D);

    // Fetch is read-only: write and mask are tied off at capture.
    assign w_req_i = '{write: 1'b0, addr: bus.i_addr, wdata: '0, wmask: '0};
    assign w_req_d = '{write: bus.d_cmd_write, addr: bus.d_addr,
                       wdata: bus.d_wdata, wmask: bus.d_wmask};

    mem_req_slot u_slot_i (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (bus.i_cmd_start),
        .i_busy  (w_busy_i),
        .i_clear (w_clear_i),
        .i_req   (w_req_i),
        .o_ready (w_ready_i),
        .o_pend  (w_pend_i),
        .o_req   (w_slot_i)
    );

    mem_req_slot u_slot_d (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (bus.d_cmd_start),
        .i_busy  (w_busy_d),
        .i_clear (w_clear_d),
        .i_req   (w_req_d),
        .o_ready (w_ready_d),
        .o_pend  (w_pend_d),
        .o_req   (w_slot_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_winner    = OWNER_D;
        w_issue     = 1'b0;
        w_clear_i   = 1'b0;
        w_clear_d   = 1'b0;
        w_rvalid_i  = 1'b0;
        w_rvalid_d  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_i || w_pend_d) begin
                    w_grant     = 1'b1;
                    w_winner    = pick_winner(ROUND_ROBIN != 0, w_pend_i,
                                              w_pend_d, r_last_grant);
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                if (bus.m_cmd_ready) begin
                    // Writes are posted: acceptance ends the transaction.
                    if (r_payload.write) begin
                        w_clear_i   = (r_owner == OWNER_I);
                        w_clear_d   = (r_owner == OWNER_D);
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT_RDATA;
                    end
                end
            end
            ST_WAIT_RDATA: begin
                if (bus.m_rdata_valid) begin
                    w_rvalid_i  = (r_owner == OWNER_I);
                    w_rvalid_d  = (r_owner == OWNER_D);
                    w_clear_i   = (r_owner == OWNER_I);
                    w_clear_d   = (r_owner == OWNER_D);
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWNER_D;
            r_last_grant <= OWNER_I;
            r_payload    <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_payload    <= (w_winner == OWNER_D) ? w_slot_d : w_slot_i;
            end
            if (bus.m_rdata_valid && (r_state != ST_WAIT_RDATA))
                r_err <= 1'b1;
        end
    end

    assign bus.i_cmd_ready   = w_ready_i;
    assign bus.d_cmd_ready   = w_ready_d;
    assign bus.i_rdata       = bus.m_rdata;
    assign bus.d_rdata       = bus.m_rdata;
    assign bus.i_rdata_valid = w_rvalid_i;
    assign bus.d_rdata_valid = w_rvalid_d;

    // Controller-facing command is forced to zero whenever not issuing.
    assign bus.m_cmd_start = w_issue;
    assign bus.m_cmd_write = w_issue & r_payload.write;
    assign bus.m_addr      = w_issue ? r_payload.addr  : '0;
    assign bus.m_wdata     = w_issue ? r_payload.wdata : '0;
    assign bus.m_wmask     = w_issue ? r_payload.wmask : '0;

    assign err_spurious = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_arbiter
// Description : Directed self-checking bench for mem_access_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_arbiter;

    logic clk;
    logic rst_n;
    logic err0, err1;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_arbiter_if if0 ();
    mem_access_arbiter_if if1 ();

    mem_access_arbiter #(.ROUND_ROBIN(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .err_spurious(err0));
    mem_access_arbiter #(.ROUND_ROBIN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .err_spurious(err1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic is; logic [31:0] ia;
        logic ds; logic dw; logic [31:0] da; logic [31:0] dwd; logic [31:0] dwm;
        logic mr; logic [31:0] mrd; logic mrv;
        logic eir; logic edr; logic ems; logic emw;
        logic [31:0] ema; logic [31:0] emwd; logic [31:0] emwm;
        logic eiv; logic edv; logic [31:0] erd; logic eerr;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(
        logic is, logic [31:0] ia, logic ds, logic dw, logic [31:0] da,
        logic [31:0] dwd, logic [31:0] dwm, logic mr, logic [31:0] mrd, logic mrv,
        logic eir, logic edr, logic ems, logic emw, logic [31:0] ema,
        logic [31:0] emwd, logic [31:0] emwm, logic eiv, logic edv,
        logic [31:0] erd, logic eerr);
        vec_t v;
        v.is = is; v.ia = ia; v.ds = ds; v.dw = dw; v.da = da; v.dwd = dwd;
        v.dwm = dwm; v.mr = mr; v.mrd = mrd; v.mrv = mrv;
        v.eir = eir; v.edr = edr; v.ems = ems; v.emw = emw; v.ema = ema;
        v.emwd = emwd; v.emwm = emwm; v.eiv = eiv; v.edv = edv; v.erd = erd;
        v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive0(input vec_t v);
        if0.i_cmd_start   = v.is;  if0.i_addr      = v.ia;
        if0.d_cmd_start   = v.ds;  if0.d_cmd_write = v.dw;
        if0.d_addr        = v.da;  if0.d_wdata     = v.dwd;
        if0.d_wmask       = v.dwm; if0.m_cmd_ready = v.mr;
        if0.m_rdata       = v.mrd; if0.m_rdata_valid = v.mrv;
    endtask

    task automatic idle0();
        drive0(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0));
    endtask

    task automatic check0(input string tag, input vec_t v);
        chk({tag, ".i_ready"}, 32'(if0.i_cmd_ready),   32'(v.eir));
        chk({tag, ".d_ready"}, 32'(if0.d_cmd_ready),   32'(v.edr));
        chk({tag, ".m_start"}, 32'(if0.m_cmd_start),   32'(v.ems));
        chk({tag, ".m_write"}, 32'(if0.m_cmd_write),   32'(v.emw));
        chk({tag, ".m_addr"},  if0.m_addr,             v.ema);
        chk({tag, ".m_wdata"}, if0.m_wdata,            v.emwd);
        chk({tag, ".m_wmask"}, if0.m_wmask,            v.emwm);
        chk({tag, ".i_rv"},    32'(if0.i_rdata_valid), 32'(v.eiv));
        chk({tag, ".d_rv"},    32'(if0.d_rdata_valid), 32'(v.edv));
        chk({tag, ".i_rdata"}, if0.i_rdata,            v.erd);
        chk({tag, ".d_rdata"}, if0.d_rdata,            v.erd);
        chk({tag, ".err"},     32'(err0),              32'(v.eerr));
    endtask

    initial begin
        int     accepts;
        int     i_sent, d_sent, ngr;
        logic   ret, last_d;
        logic [31:0] exp_addr;

        // Columns: is ia ds dw da dwd dwm mr mrd mrv | eir edr ems emw ema emwd emwm eiv edv erd err
        // Single I read of 0x4
        vecs[0]  = mk(1,32'h4,0,0,0,0,0,0,0,0,                          1,1,0,0,0,0,0,0,0,0,0);
        vecs[1]  = mk(0,0,0,0,0,0,0,0,0,0,                              0,1,0,0,0,0,0,0,0,0,0);
        vecs[2]  = mk(0,0,0,0,0,0,0,1,0,0,                              0,1,1,0,32'h4,0,0,0,0,0,0);
        vecs[3]  = mk(0,0,0,0,0,0,0,0,32'hdeadbeef,1,                   0,1,0,0,0,0,0,1,0,32'hdeadbeef,0);
        vecs[4]  = mk(0,0,0,0,0,0,0,0,0,0,                              1,1,0,0,0,0,0,0,0,0,0);
        // D posted write
        vecs[5]  = mk(0,0,1,1,32'h8,32'h12345678,32'hffffffff,0,0,0,    1,1,0,0,0,0,0,0,0,0,0);
        vecs[6]  = mk(0,0,0,0,0,0,0,0,0,0,                              1,0,0,0,0,0,0,0,0,0,0);
        vecs[7]  = mk(0,0,0,0,0,0,0,1,0,0,                              1,0,1,1,32'h8,32'h12345678,32'hffffffff,0,0,0,0);
        vecs[8]  = mk(0,0,0,0,0,0,0,0,0,0,                              1,1,0,0,0,0,0,0,0,0,0);
        // Simultaneous I read 0x0 and D read 0x10: D first under fixed priority
        vecs[9]  = mk(1,32'h0,1,0,32'h10,0,0,0,0,0,                     1,1,0,0,0,0,0,0,0,0,0);
        vecs[10] = mk(0,0,0,0,0,0,0,0,0,0,                              0,0,0,0,0,0,0,0,0,0,0);
        vecs[11] = mk(0,0,0,0,0,0,0,1,0,0,                              0,0,1,0,32'h10,0,0,0,0,0,0);
        vecs[12] = mk(0,0,0,0,0,0,0,0,32'haaaa5555,1,                   0,0,0,0,0,0,0,0,1,32'haaaa5555,0);
        vecs[13] = mk(0,0,0,0,0,0,0,0,0,0,                              0,1,0,0,0,0,0,0,0,0,0);
        vecs[14] = mk(0,0,0,0,0,0,0,1,0,0,                              0,1,1,0,32'h0,0,0,0,0,0,0);
        vecs[15] = mk(0,0,0,0,0,0,0,0,32'h11112222,1,                   0,1,0,0,0,0,0,1,0,32'h11112222,0);
        vecs[16] = mk(0,0,0,0,0,0,0,0,0,0,                              1,1,0,0,0,0,0,0,0,0,0);

        rst_n = 1'b0;
        idle0();
        if1.i_cmd_start = 0; if1.i_addr = 0; if1.d_cmd_start = 0; if1.d_cmd_write = 0;
        if1.d_addr = 0; if1.d_wdata = 0; if1.d_wmask = 0;
        if1.m_cmd_ready = 0; if1.m_rdata = 0; if1.m_rdata_valid = 0;
        repeat (3) @(negedge clk);
        #1;
        check0("reset", mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            drive0(vecs[k]);
            #1;
            check0($sformatf("vec%0d", k), vecs[k]);
        end

        // Controller stalls for 5 cycles while a D write is issued
        accepts = 0;
        @(negedge clk);
        drive0(mk(0,0,1,1,32'h40,32'hcafef00d,32'h0000ffff,0,0,0, 0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        idle0();
        #1 chk("stall.d_ready_pend", 32'(if0.d_cmd_ready), 32'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            #1;
            chk($sformatf("stall%0d.m_start", s), 32'(if0.m_cmd_start), 32'd1);
            chk($sformatf("stall%0d.m_write", s), 32'(if0.m_cmd_write), 32'd1);
            chk($sformatf("stall%0d.m_addr", s),  if0.m_addr,  32'h40);
            chk($sformatf("stall%0d.m_wdata", s), if0.m_wdata, 32'hcafef00d);
            chk($sformatf("stall%0d.m_wmask", s), if0.m_wmask, 32'h0000ffff);
            if (if0.m_cmd_start && if0.m_cmd_ready) accepts++;
        end
        @(negedge clk);
        if0.m_cmd_ready = 1'b1;
        #1;
        chk("stall.accept_start", 32'(if0.m_cmd_start), 32'd1);
        if (if0.m_cmd_start && if0.m_cmd_ready) accepts++;
        @(negedge clk);
        if0.m_cmd_ready = 1'b0;
        #1;
        if (if0.m_cmd_start && if0.m_cmd_ready) accepts++;
        chk("stall.after_start", 32'(if0.m_cmd_start), 32'd0);
        chk("stall.d_ready_back", 32'(if0.d_cmd_ready), 32'd1);
        chk("stall.accepts", 32'(accepts), 32'd1);

        // Spurious read data while idle
        @(negedge clk);
        if0.m_rdata = 32'h55; if0.m_rdata_valid = 1'b1;
        #1;
        chk("spur.i_rv", 32'(if0.i_rdata_valid), 32'd0);
        chk("spur.d_rv", 32'(if0.d_rdata_valid), 32'd0);
        chk("spur.err_before", 32'(err0), 32'd0);
        @(negedge clk);
        if0.m_rdata_valid = 1'b0;
        #1 chk("spur.err_set", 32'(err0), 32'd1);

        // Reset while waiting for read data
        @(negedge clk);
        if0.i_cmd_start = 1'b1; if0.i_addr = 32'h30;
        @(negedge clk);
        if0.i_cmd_start = 1'b0;
        @(negedge clk);
        if0.m_cmd_ready = 1'b1;
        #1 chk("rstw.issue", 32'(if0.m_cmd_start), 32'd1);
        @(negedge clk);
        if0.m_cmd_ready = 1'b0;
        #1 chk("rstw.wait_i_ready", 32'(if0.i_cmd_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        if0.m_rdata_valid = 1'b1;
        #1;
        chk("rstw.i_ready", 32'(if0.i_cmd_ready), 32'd1);
        chk("rstw.d_ready", 32'(if0.d_cmd_ready), 32'd1);
        chk("rstw.err", 32'(err0), 32'd0);
        chk("rstw.i_rv", 32'(if0.i_rdata_valid), 32'd0);
        chk("rstw.m_start", 32'(if0.m_cmd_start), 32'd0);
        if0.m_rdata_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin DUT: both ports request 4 times continuously
        i_sent = 0; d_sent = 0; ngr = 0; ret = 1'b0; last_d = 1'b0;
        for (int cyc = 0; cyc < 200 && (ngr < 8 || ret); cyc++) begin
            @(negedge clk);
            if1.i_cmd_start   = (i_sent < 4);
            if1.i_addr        = 32'h100 + 32'(i_sent * 4);
            if1.d_cmd_start   = (d_sent < 4);
            if1.d_cmd_write   = 1'b0;
            if1.d_addr        = 32'h200 + 32'(d_sent * 4);
            if1.m_cmd_ready   = 1'b1;
            if1.m_rdata_valid = ret;
            if1.m_rdata       = 32'hbeef0000 + 32'(ngr);
            #1;
            if (ret) begin
                chk("rr.route_i", 32'(if1.i_rdata_valid), 32'(!last_d));
                chk("rr.route_d", 32'(if1.d_rdata_valid), 32'(last_d));
            end
            ret = 1'b0;
            if (if1.m_cmd_start) begin
                if (ngr < 8) begin
                    exp_addr = ((ngr % 2) == 0) ? 32'h200 + 32'((ngr / 2) * 4)
                                                : 32'h100 + 32'((ngr / 2) * 4);
                    chk($sformatf("rr.grant%0d_addr", ngr), if1.m_addr, exp_addr);
                end
                last_d = if1.m_addr[9];
                ngr++;
                ret = 1'b1;
            end
            if (if1.i_cmd_start && if1.i_cmd_ready) i_sent++;
            if (if1.d_cmd_start && if1.d_cmd_ready) d_sent++;
        end
        @(negedge clk);
        if1.i_cmd_start = 1'b0; if1.d_cmd_start = 1'b0;
        if1.m_cmd_ready = 1'b0; if1.m_rdata_valid = 1'b0;
        chk("rr.grants", 32'(ngr), 32'd8);
        chk("rr.err", 32'(err1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
